// File: rtl/wb_stream_writer_core.sv
// wb_stream_writer_core
//   Wishbone-master DMA engine for the streamer write path. Words arrive on a
//   valid/ready stream, are buffered in an internal first-word-fall-through
//   FIFO, and are written to a linear memory buffer as incrementing Wishbone
//   bursts.
//
// Handshake rules: the stream side transfers a word on every rising edge where
// stream_s_valid_i and stream_s_ready_o are both high; ready depends only on
// registered state, never combinationally on valid. The Wishbone side holds
// cyc/stb for a whole burst; each rising edge with ack (and no err) retires one
// beat, and err ends the transfer without retiring the beat.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   wbm_*                      Wishbone master (write-only, incrementing bursts)
//   stream_s_*                 input word stream
//   enable                     one-cycle start pulse (honoured only when idle)
//   start_adr                  buffer base, byte address, word-aligned
//   buf_size                   transfer length in words
//   burst_size                 maximum burst length in words
//   busy, err, tx_cnt          status: transfer running, sticky bus error,
//                              words acknowledged in this transfer
module wb_stream_writer_core #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 6
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic [WB_DW-1:0]   stream_s_data_i,
    input  logic               stream_s_valid_i,
    output logic               stream_s_ready_o,
    input  logic               enable,
    input  logic [WB_AW-1:0]   start_adr,
    input  logic [WB_AW-1:0]   buf_size,
    input  logic [WB_AW-1:0]   burst_size,
    output logic               busy,
    output logic               err,
    output logic [WB_DW-1:0]   tx_cnt
);

    localparam int                 DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [WB_AW-1:0]   DEPTH_W   = WB_AW'(DEPTH);
    localparam logic [WB_AW-1:0]   ONE_W     = WB_AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t state, state_next;

    logic [WB_DW-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_count;

    logic [WB_AW-1:0] adr, buf_size_q, eff_burst, accepted_cnt, beats_left;
    logic [WB_AW-1:0] rem, len, eff_in;
    logic [WB_DW-1:0] tx_cnt_q;
    logic             busy_q, err_q;
    logic             start, go, push, pop, flush, fifo_full, bus_err;

    // wbm_dat_i is not needed by a write-only master.
    logic unused_dat;
    assign unused_dat = ^wbm_dat_i;

    // Clamp the requested burst length to [1, FIFO depth]; a longer burst
    // could never be satisfied because the FIFO would never hold enough words.
    always_comb begin
        eff_in = burst_size;
        if (burst_size == '0)
            eff_in = ONE_W;
        else if (burst_size > DEPTH_W)
            eff_in = DEPTH_W;
    end

    assign rem       = buf_size_q - WB_AW'(tx_cnt_q);
    assign len       = (eff_burst < rem) ? eff_burst : rem;
    assign fifo_full = (fifo_count == DEPTH_CNT);

    assign stream_s_ready_o = busy_q && !fifo_full && (accepted_cnt < buf_size_q);
    assign push             = stream_s_valid_i && stream_s_ready_o;

    assign start   = (state == S_IDLE) && enable;
    // A burst only starts once every beat it will need is already buffered,
    // so stb never has to stall mid-burst waiting for stream data.
    assign go      = (state == S_WAIT) && (rem != '0) && (WB_AW'(fifo_count) >= len);
    // err wins over a simultaneous ack.
    assign bus_err = (state == S_BURST) && wbm_err_i;
    assign pop     = (state == S_BURST) && wbm_ack_i && !wbm_err_i;
    assign flush   = start || bus_err;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (enable) state_next = S_WAIT;
            S_WAIT: begin
                if (rem == '0)
                    state_next = S_IDLE;
                else if (go)
                    state_next = S_BURST;
            end
            S_BURST: begin
                if (wbm_err_i)
                    state_next = S_IDLE;
                else if (wbm_ack_i && (beats_left == ONE_W))
                    state_next = S_WAIT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Transfer bookkeeping
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adr          <= '0;
            buf_size_q   <= '0;
            eff_burst    <= ONE_W;
            accepted_cnt <= '0;
            beats_left   <= '0;
            tx_cnt_q     <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (push)
                accepted_cnt <= accepted_cnt + ONE_W;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        adr          <= start_adr;
                        buf_size_q   <= buf_size;
                        eff_burst    <= eff_in;
                        accepted_cnt <= '0;
                        tx_cnt_q     <= '0;
                        err_q        <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rem == '0)
                        busy_q <= 1'b0;
                    else if (go)
                        beats_left <= len;
                end
                S_BURST: begin
                    if (wbm_err_i) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (wbm_ack_i) begin
                        adr        <= adr + WB_AW'(4);
                        tx_cnt_q   <= tx_cnt_q + WB_DW'(1);
                        beats_left <= beats_left - ONE_W;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr] <= stream_s_data_i;
    end

    assign wbm_cyc_o = (state == S_BURST);
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = wbm_cyc_o;
    assign wbm_sel_o = '1;
    assign wbm_bte_o = 2'b00;
    assign wbm_cti_o = !wbm_cyc_o ? 3'b000 :
                       (beats_left == ONE_W) ? 3'b111 : 3'b010;
    assign wbm_adr_o = adr;
    assign wbm_dat_o = mem[rd_ptr];

    assign busy   = busy_q;
    assign err    = err_q;
    assign tx_cnt = tx_cnt_q;

endmodule

// File: tb/tb_wb_stream_writer_core.sv
// Directed bench for wb_stream_writer_core: stream source and Wishbone slave
// run in one background process; the test sequence, expected values and the
// checks live in the main initial block.
module tb_wb_stream_writer_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, tx_cnt;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] stream_s_data_i, start_adr, buf_size, burst_size;
    logic        stream_s_valid_i, stream_s_ready_o, enable, busy, err;

    always #5 clk = ~clk;

    wb_stream_writer_core #(.WB_AW(32), .WB_DW(32), .FIFO_AW(6)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .stream_s_data_i(stream_s_data_i), .stream_s_valid_i(stream_s_valid_i),
        .stream_s_ready_o(stream_s_ready_o), .enable(enable),
        .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
        .busy(busy), .err(err), .tx_cnt(tx_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Captured bus traffic and stream bookkeeping
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    logic [2:0]  wr_cti[$];
    int          bursts[$];
    logic [31:0] exp_q[$];
    int          acc_cnt, acc_start, prev_acc_start, cyc_cycles, busy_cycles, beat_idx;
    int          cfg_buf, cfg_eff, exp_len;
    logic        cyc_prev, err_pending, cyc_after_err;
    bit          valid_rand, ack_rand, err_arm;
    logic [31:0] dat_base;

    // Stream source + Wishbone slave + bus monitor. Inputs change on the
    // falling edge; the sample #1 later describes what the next rising edge does.
    initial begin
        stream_s_valid_i = 1'b0; stream_s_data_i = '0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
        cyc_prev = 1'b0; err_pending = 1'b0; cyc_after_err = 1'b1;
        valid_rand = 0; ack_rand = 0; err_arm = 0; dat_base = '0;
        acc_cnt = 0; prev_acc_start = 0; cyc_cycles = 0; busy_cycles = 0; beat_idx = 0;
        cfg_buf = 0; cfg_eff = 1;
        forever begin
            @(negedge clk);
            stream_s_valid_i = valid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            stream_s_data_i  = dat_base + 32'(acc_cnt);
            wbm_err_i = 1'b0;
            if (wbm_cyc_o && err_arm && beat_idx == 2) begin
                wbm_ack_i = 1'b1; wbm_err_i = 1'b1; err_arm = 0;
            end else if (wbm_cyc_o)
                wbm_ack_i = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            else
                wbm_ack_i = 1'b0;
            #1;
            if (err_pending) begin cyc_after_err = wbm_cyc_o; err_pending = 1'b0; end
            acc_start = acc_cnt;
            if (wbm_cyc_o && !cyc_prev) begin
                exp_len = (cfg_buf - wr_adr.size() < cfg_eff) ? cfg_buf - wr_adr.size() : cfg_eff;
                check("fifo_filled_at_burst", 32'(prev_acc_start - wr_adr.size() >= exp_len), 32'd1);
                check("stb_at_burst", 32'(wbm_stb_o), 32'd1);
                check("we_at_burst", 32'(wbm_we_o), 32'd1);
                bursts.push_back(0);
            end
            if (stream_s_valid_i && stream_s_ready_o) acc_cnt++;
            if (wbm_cyc_o) cyc_cycles++;
            if (busy) busy_cycles++;
            if (wbm_cyc_o && wbm_ack_i && !wbm_err_i) begin
                wr_adr.push_back(wbm_adr_o);
                wr_dat.push_back(wbm_dat_o);
                wr_cti.push_back(wbm_cti_o);
                if (bursts.size() > 0) bursts[bursts.size()-1]++;
            end
            if (wbm_cyc_o && (wbm_ack_i || wbm_err_i)) beat_idx++;
            if (wbm_cyc_o && wbm_err_i) err_pending = 1'b1;
            cyc_prev = wbm_cyc_o;
            prev_acc_start = acc_start;
        end
    end

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] bs, input logic [31:0] db);
        @(negedge clk);
        wr_adr.delete(); wr_dat.delete(); wr_cti.delete(); bursts.delete();
        acc_cnt = 0; prev_acc_start = 0; cyc_cycles = 0; busy_cycles = 0; beat_idx = 0;
        dat_base = db;
        cfg_buf = int'(b);
        cfg_eff = (bs == 0) ? 1 : ((bs > 64) ? 64 : int'(bs));
        start_adr = a; buf_size = b; burst_size = bs; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        repeat (3) @(negedge clk);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        check("done_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Writes must be n consecutive words from base_adr carrying the stream in
    // order, chopped into bursts of eff (last burst shorter), cti=111 on each
    // burst's final beat.
    task automatic check_writes(input string tag, input int n, input logic [31:0] base_adr,
                                input logic [31:0] base_dat, input int eff);
        int exp_b[$];
        int r, l, b, j, m;
        check({tag, "_count"}, 32'(wr_adr.size()), 32'(n));
        r = n;
        while (r > 0) begin l = (r < eff) ? r : eff; exp_b.push_back(l); r -= l; end
        check({tag, "_nbursts"}, 32'(bursts.size()), 32'(exp_b.size()));
        m = (bursts.size() < exp_b.size()) ? bursts.size() : exp_b.size();
        for (int i = 0; i < m; i++) check({tag, "_burst_len"}, 32'(bursts[i]), 32'(exp_b[i]));
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base_dat + 32'(i));
        m = (wr_adr.size() < n) ? wr_adr.size() : n;
        b = 0; j = 0;
        for (int i = 0; i < m; i++) begin
            check({tag, "_adr"}, wr_adr[i], base_adr + 32'(4 * i));
            check({tag, "_dat"}, wr_dat[i], exp_q.pop_front());
            check({tag, "_cti"}, 32'(wr_cti[i]), (j == exp_b[b] - 1) ? 32'd7 : 32'd2);
            j++;
            if (j == exp_b[b]) begin b++; j = 0; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n0;
        rst = 1'b1; enable = 1'b0; start_adr = '0; buf_size = '0; burst_size = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(wbm_stb_o), 32'd0);
        check("rst_ready", 32'(stream_s_ready_o), 32'd0);
        check("rst_tx_cnt", tx_cnt, 32'd0);

        // Two full bursts of 8
        start_xfer(32'h1000, 32'd16, 32'd8, 32'h1100_0000);
        wait_done(500);
        check_writes("t1", 16, 32'h1000, 32'h1100_0000, 8);
        check("t1_tx_cnt", tx_cnt, 32'd16);
        check("t1_err", 32'(err), 32'd0);
        check("t1_cyc_cycles", 32'(cyc_cycles), 32'd16);

        // 4 + 4 + 2, stream cut off after 10 words
        start_xfer(32'h1000, 32'd10, 32'd4, 32'h2200_0000);
        wait_done(500);
        check_writes("t2", 10, 32'h1000, 32'h2200_0000, 4);
        check("t2_last_adr", (wr_adr.size() > 0) ? wr_adr[$] : 32'h0, 32'h1024);
        check("t2_accepted", 32'(acc_cnt), 32'd10);
        check("t2_ready", 32'(stream_s_ready_o), 32'd0);
        check("t2_tx_cnt", tx_cnt, 32'd10);

        // Random stream gaps and slave wait states
        valid_rand = 1; ack_rand = 1;
        start_xfer(32'h6000, 32'd37, 32'd8, 32'h3300_0000);
        wait_done(5000);
        valid_rand = 0; ack_rand = 0;
        check_writes("t3", 37, 32'h6000, 32'h3300_0000, 8);
        check("t3_tx_cnt", tx_cnt, 32'd37);

        // burst_size clamps
        start_xfer(32'h7000, 32'd3, 32'd0, 32'h4400_0000);
        wait_done(500);
        check_writes("t4a", 3, 32'h7000, 32'h4400_0000, 1);
        start_xfer(32'h8000, 32'd70, 32'd1000, 32'h5500_0000);
        wait_done(1000);
        check_writes("t4b", 70, 32'h8000, 32'h5500_0000, 64);
        check("t4b_cyc_cycles", 32'(cyc_cycles), 32'd70);

        // Bus error on third beat (ack raised too), then clean restart
        err_arm = 1; cyc_after_err = 1'b1;
        start_xfer(32'h2000, 32'd16, 32'd8, 32'h6600_0000);
        wait_done(500);
        check("t5_err", 32'(err), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_tx_cnt", tx_cnt, 32'd2);
        check("t5_writes", 32'(wr_adr.size()), 32'd2);
        check("t5_cyc_after_err", 32'(cyc_after_err), 32'd0);
        start_xfer(32'h3000, 32'd4, 32'd4, 32'h7700_0000);
        check("t5b_err_cleared", 32'(err), 32'd0);
        check("t5b_busy", 32'(busy), 32'd1);
        wait_done(500);
        check_writes("t5b", 4, 32'h3000, 32'h7700_0000, 4);
        check("t5b_tx_cnt", tx_cnt, 32'd4);

        // enable while busy is ignored
        start_xfer(32'h4000, 32'd16, 32'd8, 32'h8800_0000);
        repeat (4) @(negedge clk);
        start_adr = 32'h9000; buf_size = 32'd2; burst_size = 32'd1; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_done(500);
        check_writes("t6", 16, 32'h4000, 32'h8800_0000, 8);
        check("t6_tx_cnt", tx_cnt, 32'd16);

        // buf_size == 0
        start_xfer(32'hA000, 32'd0, 32'd8, 32'h9900_0000);
        repeat (8) @(negedge clk);
        check("t7_busy_cycles", 32'(busy_cycles), 32'd1);
        check("t7_cyc_cycles", 32'(cyc_cycles), 32'd0);
        check("t7_tx_cnt", tx_cnt, 32'd0);

        // Reset in the middle of a burst
        start_xfer(32'h5000, 32'd16, 32'd8, 32'hAA00_0000);
        for (int i = 0; i < 200 && wr_adr.size() < 3; i++) @(negedge clk);
        check("t8_reach_burst", 32'(wr_adr.size() >= 3), 32'd1);
        check("t8_cyc_before", 32'(wbm_cyc_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t8_cyc", 32'(wbm_cyc_o), 32'd0);
        check("t8_stb", 32'(wbm_stb_o), 32'd0);
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_err", 32'(err), 32'd0);
        check("t8_ready", 32'(stream_s_ready_o), 32'd0);
        check("t8_tx_cnt", tx_cnt, 32'd0);
        rst = 1'b0;
        n0 = wr_adr.size();
        repeat (6) @(negedge clk);
        check("t8_no_more_beats", 32'(wr_adr.size()), 32'(n0));
        check("t8_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
